or_nbit_pipe: RTL and testbench

//  Parametrised successor to the 1-bit OR fabric testcase: WIDTH-bit two-operand logic unit.

---
 rtl/or_nbit_pkg.sv | 32 +++
 rtl/or_nbit_pipe_if.sv | 28 ++
 rtl/or_nbit_stage.sv | 27 ++
 rtl/or_nbit_pipe.sv | 91 +++++++++
 tb/tb_or_nbit_pipe.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/or_nbit_pkg.sv
// Shared types and helpers for the WIDTH-bit logic unit.
// Op encoding, width limits and the combinational op function.
package or_nbit_pkg;

  localparam int WIDTH_MAX = 64;
  localparam int PIPE_MAX  = 4;

  typedef enum logic [1:0] {
    OP_OR  = 2'd0,
    OP_AND = 2'd1,
    OP_XOR = 2'd2,
    OP_ACC = 2'd3
  } op_t;

  // ACC returns a|b; the caller folds in the accumulator base.
  function automatic logic [WIDTH_MAX-1:0] logic_op(
    input op_t                  op,
    input logic [WIDTH_MAX-1:0] a,
    input logic [WIDTH_MAX-1:0] b
  );
    logic [WIDTH_MAX-1:0] r;
    r = '0;
    unique case (op)
      OP_OR:  r = a | b;
      OP_AND: r = a & b;
      OP_XOR: r = a ^ b;
      OP_ACC: r = a | b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/or_nbit_pipe_if.sv
// Operand/result bundle for or_nbit_pipe.
// master drives operands, slave is the logic unit.
interface or_nbit_pipe_if
  import or_nbit_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic             in_valid;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_clr;
  logic [WIDTH-1:0] c;
  logic             out_valid;
  logic             c_any;

  modport master (
    output in_valid, op, a, b, acc_clr,
    input  c, out_valid, c_any
  );

  modport slave (
    input  in_valid, op, a, b, acc_clr,
    output c, out_valid, c_any
  );

endinterface

// File: rtl/or_nbit_stage.sv
// One delay stage of the result pipeline.
// Valid always shifts; data only loads behind a valid.
module or_nbit_stage #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         src_valid,
  input  logic [W-1:0] src_data,
  output logic         valid,
  output logic [W-1:0] data
);

  // Shift valid each cycle, hold data across bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= src_valid;
      if (src_valid) begin
        data <= src_data;
      end
    end
  end

endmodule

// File: rtl/or_nbit_pipe.sv
// WIDTH-bit OR/AND/XOR/sticky-OR unit with PIPE-cycle latency.
// Stage 0 computes and accumulates; later stages only delay.
module or_nbit_pipe
  import or_nbit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PIPE  = 2
) (
  input logic           clock0,
  input logic           global_resetn,
  or_nbit_pipe_if.slave bus
);

  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $fatal(1, "or_nbit_pipe: WIDTH out of range");
  end

  if (PIPE < 1 || PIPE > PIPE_MAX) begin : g_bad_pipe
    $fatal(1, "or_nbit_pipe: PIPE out of range");
  end

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] lop;
  logic [WIDTH-1:0] r;
  logic             is_acc;

  logic             v0;
  logic [WIDTH:0]   d0;

  logic             sv [PIPE];
  logic [WIDTH:0]   sd [PIPE];

  // Stage-0 result; a same-cycle clear is applied before accumulating.
  always_comb begin
    is_acc = (bus.op == OP_ACC);
    base   = bus.acc_clr ? '0 : acc;
    lop    = WIDTH'(logic_op(bus.op,
                             WIDTH_MAX'(bus.a),
                             WIDTH_MAX'(bus.b)));
    r      = lop;
    if (is_acc) begin
      r = base | lop;
    end
  end

  // Sticky accumulator: only ACC beats or a clear change it.
  always_ff @(posedge clock0) begin
    if (!global_resetn) begin
      acc <= '0;
    end else if (bus.in_valid && is_acc) begin
      acc <= r;
    end else if (bus.acc_clr) begin
      acc <= '0;
    end
  end

  // Stage-0 register carries {any, result} so c_any tracks c.
  always_ff @(posedge clock0) begin
    if (!global_resetn) begin
      v0 <= 1'b0;
      d0 <= '0;
    end else begin
      v0 <= bus.in_valid;
      if (bus.in_valid) begin
        d0 <= {|r, r};
      end
    end
  end

  assign sv[0] = v0;
  assign sd[0] = d0;

  for (genvar k = 1; k < PIPE; k++) begin : g_stage
    or_nbit_stage #(
      .W(WIDTH + 1)
    ) u_stage (
      .clk      (clock0),
      .rst_n    (global_resetn),
      .src_valid(sv[k-1]),
      .src_data (sd[k-1]),
      .valid    (sv[k]),
      .data     (sd[k])
    );
  end

  assign bus.out_valid = sv[PIPE-1];
  assign bus.c         = sd[PIPE-1][WIDTH-1:0];
  assign bus.c_any     = sd[PIPE-1][WIDTH];

endmodule

// File: tb/tb_or_nbit_pipe.sv
// Random + directed bench for or_nbit_pipe at PIPE=1 and PIPE=4.
// Both DUTs see identical stimulus; a per-edge history model predicts outputs.
module tb_or_nbit_pipe;
  import or_nbit_pkg::*;

  localparam int HN = 2048;

  logic clk;
  logic rst_n;

  or_nbit_pipe_if #(.WIDTH(8)) b1 ();
  or_nbit_pipe_if #(.WIDTH(8)) b4 ();

  or_nbit_pipe #(.WIDTH(8), .PIPE(1)) u_p1 (
    .clock0       (clk),
    .global_resetn(rst_n),
    .bus          (b1.slave)
  );

  or_nbit_pipe #(.WIDTH(8), .PIPE(4)) u_p4 (
    .clock0       (clk),
    .global_resetn(rst_n),
    .bus          (b4.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int edge_n   = 0;

  bit         h_rst [HN];
  bit         h_v   [HN];
  logic [7:0] h_r   [HN];
  logic [7:0] acc_m = 8'h00;
  logic [7:0] exp_c [2];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge; record what the spec says that edge does.
  task automatic tick();
    int         n;
    logic [7:0] r;
    logic [7:0] base;
    @(posedge clk);
    n = edge_n;
    base = b1.acc_clr ? 8'h00 : acc_m;
    case (int'(b1.op))
      0: r = b1.a | b1.b;
      1: r = b1.a & b1.b;
      2: r = b1.a ^ b1.b;
      default: r = base | b1.a | b1.b;
    endcase
    h_rst[n] = !rst_n;
    h_v[n]   = rst_n && b1.in_valid;
    h_r[n]   = r;
    if (!rst_n) acc_m = 8'h00;
    else if (b1.in_valid && b1.op == OP_ACC) acc_m = r;
    else if (b1.acc_clr) acc_m = 8'h00;
    edge_n = n + 1;
    #1;
  endtask

  task automatic drive(input bit v, input int o,
                       input logic [7:0] a, input logic [7:0] b,
                       input bit clr);
    b1.in_valid = v; b4.in_valid = v;
    b1.op = op_t'(o[1:0]); b4.op = op_t'(o[1:0]);
    b1.a = a; b4.a = a;
    b1.b = b; b4.b = b;
    b1.acc_clr = clr; b4.acc_clr = clr;
    tick();
  endtask

  task automatic idle();
    drive(1'b0, $urandom_range(0, 3),
          8'($urandom), 8'($urandom), 1'b0);
  endtask

  // Wait (bounded) for each DUT's next result and compare to a constant.
  task automatic expect_out(input string tag, input logic [7:0] exp);
    bit s1 = 0;
    bit s4 = 0;
    repeat (8) begin
      if (!s1 && b1.out_valid) begin
        chk({tag, ".p1.c"}, b1.c, exp);
        chk({tag, ".p1.any"}, b1.c_any, |exp);
        s1 = 1;
      end
      if (!s4 && b4.out_valid) begin
        chk({tag, ".p4.c"}, b4.c, exp);
        chk({tag, ".p4.any"}, b4.c_any, |exp);
        s4 = 1;
      end
      idle();
    end
    chk({tag, ".p1.seen"}, s1, 1);
    chk({tag, ".p4.seen"}, s4, 1);
  endtask

  // Expected outputs after edge m for a DUT of latency p.
  task automatic mon(input int idx, input int p,
                     input logic ov, input logic [7:0] c,
                     input logic ca);
    int m;
    int src;
    bit ev;
    m   = edge_n - 1;
    src = m - p + 1;
    ev  = (src >= 0) && h_v[src];
    for (int j = src + 1; j <= m; j++) begin
      if (j >= 0 && h_rst[j]) ev = 0;
    end
    if (h_rst[m]) exp_c[idx] = 8'h00;
    else if (ev) exp_c[idx] = h_r[src];
    chk($sformatf("p%0d.out_valid@%0d", p, m), ov, ev);
    chk($sformatf("p%0d.c@%0d", p, m), c, exp_c[idx]);
    chk($sformatf("p%0d.c_any@%0d", p, m), ca, |exp_c[idx]);
  endtask

  initial begin
    exp_c[0] = 8'h00;
    exp_c[1] = 8'h00;
    forever begin
      @(negedge clk);
      if (edge_n > 0) begin
        mon(0, 1, b1.out_valid, b1.c, b1.c_any);
        mon(1, 4, b4.out_valid, b4.c, b4.c_any);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    // Reset held with live-looking traffic.
    repeat (3) drive(1'b1, $urandom_range(0, 3),
                     8'($urandom), 8'($urandom), 1'b0);
    rst_n = 1'b1;
    repeat (5) idle();

    // Basic ops.
    drive(1'b1, 0, 8'hA5, 8'h0F, 1'b0);
    expect_out("or", 8'hAF);
    drive(1'b1, 1, 8'hA5, 8'h0F, 1'b0);
    expect_out("and", 8'h05);
    drive(1'b1, 2, 8'hA5, 8'h0F, 1'b0);
    expect_out("xor", 8'hAA);

    // Streaming, then hold.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, $urandom_range(0, 2),
            8'($urandom), 8'($urandom), 1'b0);
    end
    repeat (8) idle();

    // Accumulate and clear.
    drive(1'b1, 3, 8'h01, 8'h00, 1'b0);
    expect_out("acc1", 8'h01);
    drive(1'b1, 3, 8'h10, 8'h02, 1'b0);
    expect_out("acc2", 8'h13);
    drive(1'b0, 0, 8'hFF, 8'hFF, 1'b1);
    drive(1'b1, 3, 8'h40, 8'h00, 1'b0);
    expect_out("acc3", 8'h40);

    // Clear-then-accumulate in one beat, and an all-zero AND.
    drive(1'b1, 3, 8'hFF, 8'h00, 1'b0);
    expect_out("accff", 8'hFF);
    drive(1'b1, 3, 8'h08, 8'h80, 1'b1);
    expect_out("clracc", 8'h88);
    drive(1'b1, 1, 8'h0F, 8'hF0, 1'b0);
    expect_out("andz", 8'h00);

    // Reset with beats in flight.
    drive(1'b1, 3, 8'h33, 8'h44, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 0, 8'($urandom), 8'($urandom), 1'b0);
    end
    rst_n = 1'b0;
    drive(1'b1, 0, 8'h5A, 8'h00, 1'b0);
    rst_n = 1'b1;
    repeat (6) idle();
    drive(1'b1, 3, 8'h00, 8'h00, 1'b0);
    expect_out("postrst", 8'h00);

    // Random soak.
    for (int i = 0; i < 300; i++) begin
      rst_n = ($urandom_range(0, 31) != 0);
      drive($urandom_range(0, 1), $urandom_range(0, 3),
            8'($urandom), 8'($urandom),
            $urandom_range(0, 7) == 0);
    end
    rst_n = 1'b1;
    repeat (8) idle();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
